// File: rtl/bus_arb_pkg.sv
// Shared types, default parameters and pointer helper for the tristate bus arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bus_arb_pkg;

   localparam int DEF_N_REQ       = 4;
   localparam int DEF_MAX_HOLD    = 4;
   localparam int DEF_TURN_CYCLES = 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      OWN   = 2'd2,
      TURN  = 2'd3
   } arb_state_t;

   // Distance of candidate c after pointer last, walking upward with wrap:
   // last+1 -> 0, last+2 -> 1, ..., last -> n-1. Never produces an index >= n.
   function automatic int dist_from_ptr(input int c, input int last, input int n);
      int d;
      d = c - last - 1;
      if (d < 0) begin
         d = d + n;
      end
      return d;
   endfunction

endpackage

// File: rtl/tristate_bus_arbiter_if.sv
// Request/release and grant/enable signals between bus masters and the arbiter.
// Latency: n/a (wiring only).
// Backpressure: masters hold req until served; grant/bus_en tell them when to drive.
interface tristate_bus_arbiter_if
   import bus_arb_pkg::*;
#(
   parameter int N_REQ = DEF_N_REQ
) ();
   localparam int ID_W = $clog2(N_REQ);

   logic [N_REQ-1:0] req;
   logic [N_REQ-1:0] done;
   logic [N_REQ-1:0] grant;
   logic [N_REQ-1:0] bus_en;
   logic [ID_W-1:0]  owner_id;
   logic             busy;

   // Arbiter side.
   modport master (
      input  req,
      input  done,
      output grant,
      output bus_en,
      output owner_id,
      output busy
   );

   // Requester side.
   modport slave (
      output req,
      output done,
      input  grant,
      input  bus_en,
      input  owner_id,
      input  busy
   );
endinterface

// File: rtl/rr_priority_picker.sv
// Round-robin pick: first set request strictly after the last pointer, with wrap.
// Latency: purely combinational.
// Backpressure: none; o_vld low when no request is set.
module rr_priority_picker
   import bus_arb_pkg::*;
#(
   parameter int N_REQ = DEF_N_REQ,
   parameter int ID_W  = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] i_req,
   input  logic [ID_W-1:0]  i_last,
   output logic             o_vld,
   output logic [ID_W-1:0]  o_winner
);

   int w_best;
   int w_dist;

   // Choose the requester with the smallest wrap distance from the pointer.
   always_comb begin
      o_vld    = 1'b0;
      o_winner = '0;
      w_best   = N_REQ;
      w_dist   = 0;
      for (int c = 0; c < N_REQ; c++) begin
         w_dist = dist_from_ptr(c, int'(i_last), N_REQ);
         if (i_req[c] && (w_dist < w_best)) begin
            w_best   = w_dist;
            o_vld    = 1'b1;
            o_winner = ID_W'(c);
         end
      end
   end

endmodule

// File: rtl/tristate_bus_arbiter.sv
// Grants one tristate-bus owner at a time: SETUP cycle, bounded OWN tenure, TURN gap.
// Latency: req -> grant after 1 edge, bus_en after 2 edges; outputs are state decodes.
// Backpressure: losers keep req high; owner leaves via done, dropping req or hold limit.
module tristate_bus_arbiter
   import bus_arb_pkg::*;
#(
   parameter int N_REQ       = DEF_N_REQ,
   parameter int MAX_HOLD    = DEF_MAX_HOLD,
   parameter int TURN_CYCLES = DEF_TURN_CYCLES
) (
   input logic                   clock,
   input logic                   reset,
   tristate_bus_arbiter_if.master arb_bus
);

   localparam int ID_W   = $clog2(N_REQ);
   localparam int HOLD_W = $clog2(MAX_HOLD + 1);
   localparam int TURN_W = $clog2(TURN_CYCLES + 1);

   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
   localparam logic [TURN_W-1:0] TURN_LAST = TURN_W'(TURN_CYCLES - 1);
   localparam logic [ID_W-1:0]   PTR_INIT  = ID_W'(N_REQ - 1);

   arb_state_t        r_state;
   arb_state_t        w_next;
   logic [ID_W-1:0]   r_owner;
   logic [ID_W-1:0]   r_last;
   logic [HOLD_W-1:0] r_hold;
   logic [TURN_W-1:0] r_turn;

   logic              w_pick_vld;
   logic [ID_W-1:0]   w_pick_id;
   logic [N_REQ-1:0]  w_owner_oh;

   rr_priority_picker #(
      .N_REQ (N_REQ),
      .ID_W  (ID_W)
   ) u_picker (
      .i_req    (arb_bus.req),
      .i_last   (r_last),
      .o_vld    (w_pick_vld),
      .o_winner (w_pick_id)
   );

   // State register; reset drops straight to IDLE so enables fall immediately.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state decision; done/req are only looked at for the current owner.
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: begin
            if (w_pick_vld) begin
               w_next = SETUP;
            end
         end
         SETUP: begin
            w_next = OWN;
         end
         OWN: begin
            if (arb_bus.done[r_owner] || !arb_bus.req[r_owner] || (r_hold == HOLD_LAST)) begin
               w_next = TURN;
            end
         end
         TURN: begin
            if (r_turn == TURN_LAST) begin
               w_next = IDLE;
            end
         end
         default: begin
            w_next = IDLE;
         end
      endcase
   end

   // Latch the winner and advance the round-robin pointer when leaving IDLE.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_owner <= '0;
         r_last  <= PTR_INIT;
      end else if ((r_state == IDLE) && w_pick_vld) begin
         r_owner <= w_pick_id;
         r_last  <= w_pick_id;
      end
   end

   // Tenure and turnaround counters; each only advances while staying in its state.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_hold <= '0;
         r_turn <= '0;
      end else begin
         case (r_state)
            SETUP: begin
               r_hold <= '0;
            end
            OWN: begin
               r_turn <= '0;
               if (w_next == OWN) begin
                  r_hold <= r_hold + 1'b1;
               end
            end
            TURN: begin
               if (w_next == TURN) begin
                  r_turn <= r_turn + 1'b1;
               end
            end
            default: begin
               r_hold <= r_hold;
            end
         endcase
      end
   end

   assign w_owner_oh = {{(N_REQ-1){1'b0}}, 1'b1} << r_owner;

   assign arb_bus.grant    = ((r_state == SETUP) || (r_state == OWN)) ? w_owner_oh : '0;
   assign arb_bus.bus_en   = (r_state == OWN) ? w_owner_oh : '0;
   assign arb_bus.owner_id = r_owner;
   assign arb_bus.busy     = (r_state != IDLE);

endmodule
